// File: rtl/tristate_bus_arbiter_if.sv
// Bus bundle between the tristate-driver requesters and the arbiter.
// Protocol: a requester holds req[i] high (level) for as long as it wants the
// net; the arbiter answers with a registered one-hot en. The owner may end
// its grant early with a one-cycle done[i] pulse or by dropping req[i].
// done from a non-owner has no effect. en is never multi-hot, and at least
// TA_CYCLES all-off cycles separate any two owners.
interface tristate_bus_arbiter_if #(
  parameter int N    = 2,
  parameter int SELW = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]    req;
  logic [N-1:0]    done;
  logic [N-1:0]    en;
  logic [SELW-1:0] sel;
  logic            busy;
  logic            ta;

  // Requester side: drives requests and early-release pulses.
  modport master (
    output req,
    output done,
    input  en,
    input  sel,
    input  busy,
    input  ta
  );

  // Arbiter side: samples requests, drives enables and select.
  modport slave (
    input  req,
    input  done,
    output en,
    output sel,
    output busy,
    output ta
  );
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Registered arbiter producing tristate enables for N drivers that share one
// net, with a guaranteed all-off turnaround window between owners.
// States: IDLE (bus floating), GRANT (one driver enabled), TURN (all-off gap).
// Optional build macro TRISTATE_BUS_ARBITER_FIXED_PRIO_EN: when defined, the
// winner is the lowest requesting index instead of the round-robin pick.
// Legal parameters: N 2..8, MAX_HOLD 1..255, TA_CYCLES 1..4.
module tristate_bus_arbiter #(
  parameter int N         = 2,
  parameter int MAX_HOLD  = 8,
  parameter int TA_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  tristate_bus_arbiter_if.slave  bus,
  output logic [1:0]             dbg_state_o
);

  localparam int SELW = (N > 1) ? $clog2(N) : 1;

  localparam logic [7:0]      HOLD_MAX  = 8'(MAX_HOLD);
  localparam logic [2:0]      TA_LOAD   = 3'(TA_CYCLES);
  localparam logic [SELW-1:0] LAST_INIT = SELW'(N - 1);
  localparam logic [N-1:0]    ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    en_q, en_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [7:0]      hold_q, hold_d;
  logic [2:0]      ta_cnt_q, ta_cnt_d;
  logic [SELW-1:0] last_q, last_d;

  logic            any_req;
  logic [SELW-1:0] win;
  logic            owner_done;
  logic            owner_req;
  logic            others_wait;
  logic            hold_full;
  logic            release_now;

  assign any_req = |bus.req;

  // Winner search over the current request vector.
`ifdef TRISTATE_BUS_ARBITER_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    // Walk downward so the lowest requesting index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req[i]) win = SELW'(i);
    end
  end
`else
  always_comb begin
    logic            found;
    logic [SELW-1:0] cand;
    win   = '0;
    found = 1'b0;
    cand  = '0;
    // Start one past the previous owner and wrap, so every requester gets a turn.
    for (int i = 0; i < N; i++) begin
      cand = SELW'((int'(last_q) + 1 + i) % N);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end
`endif

  // Release qualifiers for the current owner (sel_q names it while in GRANT).
  always_comb begin
    owner_done  = bus.done[sel_q];
    owner_req   = bus.req[sel_q];
    others_wait = |(bus.req & ~en_q);
    hold_full   = (hold_q == HOLD_MAX);
    release_now = owner_done || !owner_req || (hold_full && others_wait);
  end

  // Next-state and next-output logic for the IDLE/GRANT/TURN machine.
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    sel_d    = sel_q;
    hold_d   = hold_q;
    ta_cnt_d = ta_cnt_q;
    last_d   = last_q;
    unique case (state_q)
      S_IDLE: begin
        en_d = '0;
        if (any_req) begin
          state_d = S_GRANT;
          en_d    = ONE_HOT0 << win;
          sel_d   = win;
          hold_d  = 8'd1;
          last_d  = win;
        end
      end
      S_GRANT: begin
        if (release_now) begin
          // done and req dropping together still count as one release.
          state_d  = S_TURN;
          en_d     = '0;
          hold_d   = 8'd0;
          ta_cnt_d = TA_LOAD;
        end else if (!hold_full) begin
          hold_d = hold_q + 8'd1;
        end
      end
      S_TURN: begin
        en_d = '0;
        if (ta_cnt_q <= 3'd1) begin
          // Last all-off cycle: hand over directly or fall back to IDLE.
          ta_cnt_d = 3'd0;
          if (any_req) begin
            state_d = S_GRANT;
            en_d    = ONE_HOT0 << win;
            sel_d   = win;
            hold_d  = 8'd1;
            last_d  = win;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          ta_cnt_d = ta_cnt_q - 3'd1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        en_d     = '0;
        hold_d   = 8'd0;
        ta_cnt_d = 3'd0;
      end
    endcase
  end

  // State and output registers; reset releases the bus with no turnaround.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      en_q     <= '0;
      sel_q    <= '0;
      hold_q   <= 8'd0;
      ta_cnt_q <= 3'd0;
      last_q   <= LAST_INIT;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      sel_q    <= sel_d;
      hold_q   <= hold_d;
      ta_cnt_q <= ta_cnt_d;
      last_q   <= last_d;
    end
  end

  assign bus.en      = en_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = (state_q == S_GRANT);
  assign bus.ta      = (state_q == S_TURN);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Bench for tristate_bus_arbiter: directed scenarios with hand-written
// expectations, then randomized requests/done pulses/resets checked every
// cycle against an ownership-level reference model.
module tb_tristate_bus_arbiter;

  localparam int N         = 3;
  localparam int MAX_HOLD  = 4;
  localparam int TA_CYCLES = 2;
  localparam int SELW      = $clog2(N);
  localparam int W         = N + SELW + 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  tristate_bus_arbiter_if #(.N(N)) bus ();

  tristate_bus_arbiter #(
    .N(N), .MAX_HOLD(MAX_HOLD), .TA_CYCLES(TA_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Tracked as "who owns the net, for how long, how much gap remains".
  typedef struct {
    int owner;  // -1 when nobody drives
    int len;    // cycles the owner has had en high
    int gap;    // all-off cycles still to come
    int last;   // previous owner for rotation
    int sel;
  } model_t;

  model_t m = '{owner: -1, len: 0, gap: 0, last: N - 1, sel: 0};

  function automatic int pick(input logic [N-1:0] r, input int last);
`ifdef TRISTATE_BUS_ARBITER_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int i = 1; i <= N; i++) begin
      int c;
      c = (last + i) % N;
      if (r[c]) return c;
    end
`endif
    return -1;
  endfunction

  function automatic model_t step(input model_t s, input logic rst, input logic [N-1:0] r,
                                  input logic [N-1:0] d);
    model_t n;
    n = s;
    if (!rst) begin
      n = '{owner: -1, len: 0, gap: 0, last: N - 1, sel: 0};
    end else if (s.owner >= 0) begin
      logic [N-1:0] others;
      others = r;
      others[s.owner] = 1'b0;
      if (d[s.owner] || !r[s.owner] || (s.len >= MAX_HOLD && others != 0)) begin
        n.owner = -1;
        n.len   = 0;
        n.gap   = TA_CYCLES;
      end else if (s.len < MAX_HOLD) begin
        n.len = s.len + 1;
      end
    end else if (s.gap > 1) begin
      n.gap = s.gap - 1;
    end else begin
      int w;
      n.gap = 0;
      w = pick(r, s.last);
      if (w >= 0) begin
        n.owner = w;
        n.len   = 1;
        n.last  = w;
        n.sel   = w;
      end
    end
    return n;
  endfunction

  function automatic logic [W-1:0] outs_of(input model_t s);
    logic [N-1:0] e;
    logic [SELW-1:0] sv;
    e  = '0;
    if (s.owner >= 0) e[s.owner] = 1'b1;
    sv = SELW'(s.sel);
    return {e, sv, (s.owner >= 0), (s.gap > 0)};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];

  always @(posedge clk) begin
    model_t nxt;
    nxt = step(m, rst_n, bus.req, bus.done);
    m <= nxt;
    exp_q.push_back(outs_of(nxt));
  end

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("model_en",   32'(bus.en),   32'(e[W-1 -: N]));
      check("model_sel",  32'(bus.sel),  32'(e[SELW+1 : 2]));
      check("model_busy", 32'(bus.busy), 32'(e[1]));
      check("model_ta",   32'(bus.ta),   32'(e[0]));
      check("onehot",     32'($countones(bus.en) <= 1), 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  logic [N-1:0]    seq_en  [16] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000,
                                    3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000,
                                    3'b001, 3'b001, 3'b001, 3'b001};
  logic [SELW-1:0] seq_sel [16] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                                    2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1,
                                    2'd0, 2'd0, 2'd0, 2'd0};

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    bus.req  = 3'b011;
    bus.done = '0;

    // Reset held with requests present.
    repeat (3) begin
      @(negedge clk);
      check("rst_en",   32'(bus.en),   32'd0);
      check("rst_sel",  32'(bus.sel),  32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_ta",   32'(bus.ta),   32'd0);
    end

    // Single request, then drop it.
    rst_n = 1'b1; bus.req = '0;
    repeat (2) @(negedge clk);
    bus.req = 3'b001;
    @(negedge clk);
    check("single_en",   32'(bus.en),   32'b001);
    check("single_busy", 32'(bus.busy), 32'd1);
    repeat (3) @(negedge clk);
    bus.req = '0;
    @(negedge clk);
    check("drop_en", 32'(bus.en), 32'd0);
    check("drop_ta1", 32'(bus.ta), 32'd1);
    @(negedge clk);
    check("drop_ta2", 32'(bus.ta), 32'd1);
    @(negedge clk);
    check("drop_idle_ta",   32'(bus.ta),   32'd0);
    check("drop_idle_busy", 32'(bus.busy), 32'd0);

    // Constant contention: fairness and turnaround spacing.
    do_reset();
    bus.req = 3'b011;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("cont_en",  32'(bus.en),  32'(seq_en[i]));
      check("cont_sel", 32'(bus.sel), 32'(seq_sel[i]));
    end

    // Early release by done from the owner.
    bus.req = '0;
    do_reset();
    bus.req = 3'b011;
    @(negedge clk);
    check("early_g1", 32'(bus.en), 32'b001);
    @(negedge clk);
    bus.done = 3'b001;
    @(negedge clk);
    bus.done = '0;
    check("early_off1", 32'(bus.en), 32'd0);
    @(negedge clk);
    check("early_off2", 32'(bus.en), 32'd0);
    @(negedge clk);
    check("early_next_en",  32'(bus.en),  32'b010);
    check("early_next_sel", 32'(bus.sel), 32'd1);

    // Sole requester keeps the bus past MAX_HOLD.
    bus.req = '0;
    do_reset();
    bus.req = 3'b010;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("nowait_en", 32'(bus.en), 32'b010);
      check("nowait_ta", 32'(bus.ta), 32'd0);
    end

    // Reset in the middle of a grant.
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_en",  32'(bus.en),  32'd0);
    check("midrst_sel", 32'(bus.sel), 32'd0);
    rst_n = 1'b1; bus.req = 3'b011;
    @(negedge clk);
    check("midrst_first_en", 32'(bus.en), 32'b001);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int b = 0; b < N; b++) begin
        if (bus.req[b]) bus.req[b] = ($urandom_range(0, 7) != 0);
        else            bus.req[b] = ($urandom_range(0, 3) == 0);
        bus.done[b] = ($urandom_range(0, 7) == 0);
      end
      rst_n = ($urandom_range(0, 199) != 0);
    end

    @(negedge clk);
    bus.req = '0; bus.done = '0; rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tristate_bus_arbiter.md
# tristate_bus_arbiter

Registered arbiter that generates the enable lines for a set of tristate drivers sharing one bus net, plus the binary select for the downstream mux/inverter stage. It grants the bus to one requester at a time. Every ownership change has a guaranteed all-off turnaround window, so two drivers never fight the net. It sits directly upstream of the tristate-pair mux cells and feeds their `en` inputs.

## Interface
- `N`, 2: number of requesters/tristate drivers; legal 2..8.
- `MAX_HOLD`, 8: maximum grant length in cycles while another requester waits; legal 1..255.
- `TA_CYCLES`, 1: all-off turnaround cycles between owners; legal 1..4.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst_n`  in  1: reset; one clock, reset is synchronous and active-low.
- `req`  in  N: request per driver; level, held high while the driver wants the bus.
- `done`  in  N: early release pulse from the current owner; ignored from non-owners.
- `en`  out  N: tristate enables; one-hot or all-zero, registered.
- `sel`  out  clog2(N): binary index of the current or last owner, registered.
- `busy`  out  1: high while in GRANT.
- `ta`  out  1: high during turnaround.

## Operation
- Three states: IDLE, GRANT and TURN.
- **IDLE**
  - `en` is all-zero.
  - If any `req` bit is high at an edge, the winner is chosen by the round-robin search, and the next state is GRANT.
  - At that same edge, `en[w]` goes to 1, `sel` is set to `w`, and the hold counter is set to 1.
- **GRANT**
  - `en[w]` stays 1 and the hold counter increments each cycle. The counter saturates at `MAX_HOLD`.
  - Release condition: `done[w]` = 1, OR `req[w]` = 0, OR (counter = `MAX_HOLD` AND any other `req` bit is high).
  - On release, the next state is TURN, `en` goes to 0 and the TA counter is loaded with `TA_CYCLES`.
  - If counter = `MAX_HOLD` and no other requester is waiting, the owner keeps the bus.
- **TURN**
  - `en` is all-zero and `ta` = 1 for exactly `TA_CYCLES` cycles.
  - At the edge ending the last TURN cycle, arbitration runs. If any `req` bit is high, the next state is GRANT to the new winner; otherwise IDLE.
  - The previous owner is eligible again, subject to round-robin order.
- **Round-robin**
  - The search starts at `(last_owner+1) mod N` and wraps.
  - `last_owner` resets to N-1, so requester 0 wins the first contested grant.
- **Select output**
  - `sel` changes only on entry to GRANT.
  - `sel` holds through TURN and IDLE, so the downstream mux select is stable while the net floats.
- **Input handling**
  - A non-owner `req` never preempts before `MAX_HOLD` is reached.
  - `done` from a non-owner is ignored.
  - `done` and `req` deasserting in the same cycle count as a single release.

## Timing
- **Reset values**
  - `en` = 0, `sel` = 0, `busy` = 0, `ta` = 0.
  - State = IDLE, hold counter = 0, TA counter = 0, `last_owner` = N-1.
- **Reset mid-operation**
  - `rst_n` low at an edge forces all reset values at that edge, regardless of state.
  - No turnaround is inserted after reset; the bus is considered released.
- **Latency**
  - `req` is sampled high at edge k in IDLE, and `en` is high after edge k. That is a 1-cycle request-to-enable latency.
  - Release seen at edge k means `en` is low after edge k.
- **Gap between owners**
  - Owner A's `en` falls at edge k, and owner B's `en` rises at edge k+`TA_CYCLES`.
  - This gives exactly `TA_CYCLES` all-zero cycles, never fewer.
- **Maximum grant length**
  - With contention, a grant lasts at most `MAX_HOLD` cycles with `en` high.
- **Invariant**
  - `en` is never multi-hot in any cycle.
  - `busy` equals the OR of `en`.

## Configuration
- `TRISTATE_BUS_ARBITER_FIXED_PRIO_EN`
  - **Defined:** the round-robin search is replaced by fixed priority, where the lowest index wins. `last_owner` is unused, and the `MAX_HOLD` preemption still applies.
  - **Undefined (default):** round-robin as specified above.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with `req`=2'b11 -> `en`=0, `sel`=0, `busy`=0, `ta`=0 throughout.
- **Single request:** N=2, `req`=2'b01 from edge 5 -> `en`=2'b01 after edge 5. Drop `req` at edge 9 -> `en`=0 after edge 9, `ta`=1 for 1 cycle, then IDLE.
- **Contention and fairness:** `req`=2'b11 constant, `MAX_HOLD`=4, `TA_CYCLES`=2 -> sequence `en`=01×4, 00×2, 10×4, 00×2, 01×4. `sel` is 0, 0, 1, 1, 0 across those segments.
- **Early release:** owner 0 with `req[1]` high, pulse `done[0]` at grant cycle 2 -> `en[0]` low next edge, and `en[1]` high exactly `TA_CYCLES` later.
- **No waiter:** `req`=2'b10 only, run 20 cycles with `MAX_HOLD`=4 -> `en`=2'b10 continuously, with no TURN.
- **Mid-grant reset:** `en`=2'b10, then `rst_n`=0 one edge -> `en`=0 and `sel`=0 at that edge. After release with `req`=2'b11, requester 0 is granted first.
